// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT spectrum capture block.
// Capture FSM states, default geometry and the component magnitude helper.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        HOLD
    } capture_state_t;

    localparam int WIDTH_DEF = 16;
    localparam int N_2_DEF   = 5;
    localparam int NBINS     = 2 ** (N_2_DEF - 1);

    // Unsigned magnitude of a sign-extended component; the most negative
    // value of a narrower field maps cleanly onto its positive counterpart.
    function automatic logic [31:0] abs_u(input logic signed [31:0] x);
        logic [31:0] r;
        r = x;
        if (x[31]) r = ~r + 32'd1;
        return r;
    endfunction

endpackage

// File: rtl/fft_mag_pipe.sv
// fft_mag_pipe: two-stage alpha-max-beta-min magnitude pipeline.
// A valid bit and the bin index travel alongside the data.
module fft_mag_pipe
    import fft_pkg::*;
#(
    parameter int width = WIDTH_DEF,
    parameter int BW    = $clog2(NBINS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [BW-1:0]      i_bin,
    input  logic [2*width-1:0] i_wd,
    output logic               o_valid,
    output logic [BW-1:0]      o_bin,
    output logic [width-1:0]   o_mag
);

    logic signed [width-1:0] w_re;
    logic signed [width-1:0] w_im;
    logic signed [31:0]      w_re_x;
    logic signed [31:0]      w_im_x;
    logic [width-1:0]        w_mx;
    logic [width-1:0]        w_mn;
    logic [width-1:0]        w_mag;

    logic                    r_v1;
    logic [BW-1:0]           r_bin1;
    logic [width-1:0]        r_are;
    logic [width-1:0]        r_aim;
    logic                    r_v2;
    logic [BW-1:0]           r_bin2;
    logic [width-1:0]        r_mag;

    assign w_re   = i_wd[2*width-1:width];
    assign w_im   = i_wd[width-1:0];
    assign w_re_x = 32'(w_re);
    assign w_im_x = 32'(w_im);

    // Largest of 1.375 * 2^(w-1) still fits in width bits.
    assign w_mx  = (r_are > r_aim) ? r_are : r_aim;
    assign w_mn  = (r_are > r_aim) ? r_aim : r_are;
    assign w_mag = w_mx + (w_mn >> 2) + (w_mn >> 3);

    // Stage 1: component magnitudes, bin index and valid
    always_ff @(posedge clk) begin
        if (reset || i_flush) r_v1 <= 1'b0;
        else                  r_v1 <= i_valid;
        r_bin1 <= i_bin;
        r_are  <= width'(abs_u(w_re_x));
        r_aim  <= width'(abs_u(w_im_x));
    end

    // Stage 2: max/min combine into the magnitude estimate
    always_ff @(posedge clk) begin
        if (reset || i_flush) r_v2 <= 1'b0;
        else                  r_v2 <= r_v1;
        r_bin2 <= r_bin1;
        r_mag  <= w_mag;
    end

    assign o_valid = r_v2;
    assign o_bin   = r_bin2;
    assign o_mag   = r_mag;

endmodule

// File: rtl/fft_spectrum_capture.sv
// fft_spectrum_capture: captures one half-spectrum of FFT magnitudes,
// tracks the non-DC peak and holds the frame until the consumer acks.
module fft_spectrum_capture
    import fft_pkg::*;
#(
    parameter int width = WIDTH_DEF,
    parameter int N_2   = N_2_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fft_done,
    input  logic [2*width-1:0] fft_wd,
    input  logic               frame_ack,
    input  logic [N_2-2:0]     spec_adr,
    output logic [width-1:0]   spec_rdata,
    output logic               frame_ready,
    output logic [N_2-2:0]     peak_bin,
    output logic [width-1:0]   peak_mag,
    output logic               overrun
);

    localparam int BW    = N_2 - 1;
    localparam int LBINS = 2 ** BW;
    localparam logic [BW-1:0] LAST = BW'(LBINS - 1);

    capture_state_t   r_state;
    capture_state_t   w_next;
    logic             r_done_q;
    logic             r_armed;
    logic [BW-1:0]    r_cnt;
    logic             w_rise;
    logic             w_abort;
    logic             w_in_valid;
    logic [BW-1:0]    w_in_bin;
    logic             w_pv;
    logic [BW-1:0]    w_pbin;
    logic [width-1:0] w_pmag;
    logic [width-1:0] r_mem [LBINS];

    // A level already high when reset releases must fall before it counts.
    assign w_rise  = fft_done & ~r_done_q & r_armed;
    assign w_abort = ((r_state == CAPTURE) || (r_state == DRAIN)) & ~fft_done;

    assign w_in_valid = ((r_state == IDLE) & w_rise) |
                        ((r_state == CAPTURE) & fft_done);
    assign w_in_bin   = (r_state == CAPTURE) ? r_cnt : '0;

    fft_mag_pipe #(
        .width (width),
        .BW    (BW)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_abort),
        .i_valid (w_in_valid),
        .i_bin   (w_in_bin),
        .i_wd    (fft_wd),
        .o_valid (w_pv),
        .o_bin   (w_pbin),
        .o_mag   (w_pmag)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state; the counter wraps to 0 entering DRAIN and runs two cycles
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_rise) w_next = CAPTURE;
            CAPTURE: if (w_abort) w_next = IDLE;
                     else if (r_cnt == LAST) w_next = DRAIN;
            DRAIN:   if (w_abort) w_next = IDLE;
                     else if (r_cnt == BW'(1)) w_next = HOLD;
            HOLD:    if (frame_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Edge detector and post-reset arming
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_done_q <= fft_done;
            if (!fft_done) r_armed <= 1'b1;
        end
    end

    // Bin counter: bin 0 goes in on the rise, so it preloads 1
    always_ff @(posedge clk) begin
        if (reset)                    r_cnt <= '0;
        else if (r_state == IDLE)     r_cnt <= BW'(1);
        else if (r_state != HOLD)     r_cnt <= r_cnt + BW'(1);
    end

    // Peak tracker over non-DC bins; strict compare keeps the lower index
    always_ff @(posedge clk) begin
        if (reset || w_abort || ((r_state == IDLE) && w_rise)) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (w_pv && (w_pbin != '0) && (w_pmag > peak_mag)) begin
            peak_bin <= w_pbin;
            peak_mag <= w_pmag;
        end
    end

    // Spectrum buffer write port
    always_ff @(posedge clk) begin
        if (w_pv && !w_abort) r_mem[w_pbin] <= w_pmag;
    end

    // Registered read port; a same-address write returns the old word
    always_ff @(posedge clk) begin
        if (reset) spec_rdata <= '0;
        else       spec_rdata <= r_mem[spec_adr];
    end

    // Frame ready mirrors HOLD; overrun is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_ready <= (w_next == HOLD);
            if ((r_state == HOLD) && w_rise) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// tb_fft_spectrum_capture: randomized and directed bench for the capture
// block against a per-frame magnitude/peak reference model.
module tb_fft_spectrum_capture;
    import fft_pkg::*;

    localparam int W  = 16;
    localparam int N2 = 5;
    localparam int NB = 2 ** (N2 - 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          fft_done;
    logic [2*W-1:0] fft_wd;
    logic          frame_ack;
    logic [N2-2:0] spec_adr;
    logic [W-1:0]  spec_rdata;
    logic          frame_ready;
    logic [N2-2:0] peak_bin;
    logic [W-1:0]  peak_mag;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] frm [NB];
    bit exp_overrun = 1'b0;

    always #5 clk = ~clk;

    fft_spectrum_capture #(
        .width (W),
        .N_2   (N2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fft_done    (fft_done),
        .fft_wd      (fft_wd),
        .frame_ack   (frame_ack),
        .spec_adr    (spec_adr),
        .spec_rdata  (spec_rdata),
        .frame_ready (frame_ready),
        .peak_bin    (peak_bin),
        .peak_mag    (peak_mag),
        .overrun     (overrun)
    );

    function automatic int ref_mag(input logic [31:0] wd);
        int re, im, ar, ai, mx, mn;
        re = int'($signed(wd[31:16]));
        im = int'($signed(wd[15:0]));
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        return mx + mn / 4 + mn / 8;
    endfunction

    function automatic void ref_peak(output int b, output int m);
        b = 0;
        m = 0;
        for (int k = 1; k < NB; k++) begin
            if (ref_mag(frm[k]) > m) begin
                m = ref_mag(frm[k]);
                b = k;
            end
        end
    endfunction

    function automatic logic [31:0] pack(input int re, input int im);
        logic [15:0] r16, i16;
        r16 = 16'(re);
        i16 = 16'(im);
        return {r16, i16};
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < NB; k++) frm[k] = '0;
    endtask

    task automatic drive_frame(input bit junk);
        fft_done = 1'b1;
        fft_wd = junk ? $urandom : frm[0];
        for (int k = 1; k < NB; k++) begin
            @(negedge clk);
            fft_wd = junk ? $urandom : frm[k];
        end
        repeat (2) begin
            @(negedge clk);
            fft_wd = $urandom;
        end
    endtask

    task automatic capture_frame(input string tag);
        drive_frame(1'b0);
        n_checks++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_early: got %b expected 0", tag, frame_ready);
        end
        @(negedge clk);
        n_checks++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_t0+18: got %b expected 1", tag, frame_ready);
        end
    endtask

    task automatic read_back_frame(input string tag);
        int pb, pm;
        ref_peak(pb, pm);
        n_checks++;
        if (peak_bin !== 4'(pb)) begin
            n_fail++;
            $display("FAIL %s peak_bin: got %0d expected %0d", tag, peak_bin, pb);
        end
        n_checks++;
        if (peak_mag !== 16'(pm)) begin
            n_fail++;
            $display("FAIL %s peak_mag: got %0d expected %0d", tag, peak_mag, pm);
        end
        n_checks++;
        if (overrun !== exp_overrun) begin
            n_fail++;
            $display("FAIL %s overrun: got %b expected %b", tag, overrun, exp_overrun);
        end
        for (int k = 0; k < NB; k++) begin
            spec_adr = 4'(k);
            @(negedge clk);
            n_checks++;
            if (spec_rdata !== 16'(ref_mag(frm[k]))) begin
                n_fail++;
                $display("FAIL %s bin%0d: got %0d expected %0d",
                         tag, k, spec_rdata, ref_mag(frm[k]));
            end
        end
    endtask

    task automatic release_frame(input string tag);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        n_checks++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack_release: got %b expected 0", tag, frame_ready);
        end
        fft_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fft_done = 1'b0;
        fft_wd = '0;
        frame_ack = 1'b0;
        spec_adr = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spec_rdata, frame_ready, peak_bin, peak_mag, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {spec_rdata, frame_ready, peak_bin, peak_mag, overrun});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 0", frame_ready);
        end
    endtask

    task automatic test_single_bin();
        clear_frame();
        frm[3] = pack(1000, 0);
        capture_frame("single");
        n_checks++;
        if (peak_bin !== 4'd3 || peak_mag !== 16'd1000) begin
            n_fail++;
            $display("FAIL single_peak: got %0d/%0d expected 3/1000", peak_bin, peak_mag);
        end
        read_back_frame("single");
        release_frame("single");
    endtask

    task automatic test_mixed();
        clear_frame();
        frm[0] = pack(32767, 0);
        frm[2] = pack(-800, 600);
        frm[7] = pack(-32768, -32768);
        capture_frame("mixed");
        n_checks++;
        if (peak_bin !== 4'd7 || peak_mag !== 16'd45056) begin
            n_fail++;
            $display("FAIL mixed_peak: got %0d/%0d expected 7/45056", peak_bin, peak_mag);
        end
        read_back_frame("mixed");
        release_frame("mixed");
    endtask

    task automatic test_tie();
        clear_frame();
        frm[5] = pack(500, 500);
        frm[9] = pack(500, 500);
        capture_frame("tie");
        n_checks++;
        if (peak_bin !== 4'd5 || peak_mag !== 16'd687) begin
            n_fail++;
            $display("FAIL tie_peak: got %0d/%0d expected 5/687", peak_bin, peak_mag);
        end
        read_back_frame("tie");
        release_frame("tie");
    endtask

    task automatic test_random(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < NB; k++) begin
                if (f % 2 == 0) frm[k] = $urandom;
                else frm[k] = pack(int'($urandom_range(0, 6)) - 3,
                                   int'($urandom_range(0, 6)) - 3);
            end
            capture_frame("random");
            read_back_frame("random");
            release_frame("random");
        end
    endtask

    task automatic test_overrun();
        for (int k = 0; k < NB; k++) frm[k] = $urandom;
        capture_frame("overrun");
        fft_done = 1'b0;
        @(negedge clk);
        drive_frame(1'b1);
        exp_overrun = 1'b1;
        n_checks++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_hold_ready: got %b expected 1", frame_ready);
        end
        read_back_frame("overrun_hold");
        release_frame("overrun_hold");
        for (int k = 0; k < NB; k++) frm[k] = $urandom;
        capture_frame("after_overrun");
        read_back_frame("after_overrun");
        release_frame("after_overrun");
    endtask

    task automatic test_abort();
        int pm;
        int bad;
        for (int k = 0; k < NB; k++) frm[k] = $urandom;
        frm[1] = pack(100, 0);
        pm = 0;
        for (int k = 1; k <= 3; k++)
            if (ref_mag(frm[k]) > pm) pm = ref_mag(frm[k]);
        fft_done = 1'b1;
        fft_wd = frm[0];
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            fft_wd = frm[k];
        end
        @(negedge clk);
        n_checks++;
        if (peak_mag !== 16'(pm)) begin
            n_fail++;
            $display("FAIL abort_pre_peak: got %0d expected %0d", peak_mag, pm);
        end
        fft_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (peak_bin !== 4'd0 || peak_mag !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_peak_clear: got %0d/%0d expected 0/0", peak_bin, peak_mag);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_ready_cycles: got %0d expected 0", bad);
        end
        capture_frame("abort_rerun");
        read_back_frame("abort_rerun");
        release_frame("abort_rerun");
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int k = 0; k < NB; k++) frm[k] = $urandom;
        fft_done = 1'b1;
        fft_wd = frm[0];
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            fft_wd = frm[k];
        end
        reset = 1'b1;
        @(negedge clk);
        exp_overrun = 1'b0;
        n_checks++;
        if ({spec_rdata, frame_ready, peak_bin, peak_mag, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {spec_rdata, frame_ready, peak_bin, peak_mag, overrun});
        end
        reset = 1'b0;
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            fft_wd = $urandom;
            if (frame_ready !== 1'b0 || peak_mag !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_high_done_no_capture: got %0d expected 0", bad);
        end
        fft_done = 1'b0;
        @(negedge clk);
        capture_frame("reset_rerun");
        read_back_frame("reset_rerun");
        release_frame("reset_rerun");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_bin();
        test_mixed();
        test_tie();
        test_random(6);
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
